// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave exposing N_RW read/write registers and N_RO read-only status words.
// Latency: write lands 1 cycle after AW+W capture, read data 1 cycle after AR; backpressure: held B/R responses stall new requests.
module axil_reg_bank #(
    parameter int ADDR_WIDTH = 32,
    parameter int N_RW       = 4,
    parameter int N_RO       = 4
) (
    input  logic                               axi_clock,
    input  logic                               axi_reset,
    input  logic [ADDR_WIDTH-1:0]              s_axi_awaddr,
    input  logic [2:0]                         s_axi_awprot,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [31:0]                        s_axi_wdata,
    input  logic [3:0]                         s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic [1:0]                         s_axi_bresp,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]              s_axi_araddr,
    input  logic [2:0]                         s_axi_arprot,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic [31:0]                        s_axi_rdata,
    output logic [1:0]                         s_axi_rresp,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
    output logic [32*N_RW-1:0]                 rw_regs,
    output logic [N_RW-1:0]                    wr_pulse,
    input  logic [32*(N_RO > 0 ? N_RO : 1)-1:0] ro_regs
);
    localparam int IW = ADDR_WIDTH - 2;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t wstate;
    rstate_t rstate;

    logic                  aw_have, w_have;
    logic [IW-1:0]         aw_idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [N_RW-1:0][31:0] rw_q, rw_next;
    logic [N_RW-1:0]       wr_hit;
    logic                  aw_hs, w_hs, ar_hs, do_write, wr_ok;
    logic [IW-1:0]         w_idx, ar_idx;
    logic [31:0]           w_data, rd_data;
    logic [3:0]            w_strb;
    logic                  rd_err;

    wire unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign aw_hs    = s_axi_awvalid & s_axi_awready;
    assign w_hs     = s_axi_wvalid & s_axi_wready;
    assign ar_hs    = s_axi_arvalid & s_axi_arready;
    assign w_idx    = aw_hs ? s_axi_awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
    assign w_data   = w_hs ? s_axi_wdata : wdata_q;
    assign w_strb   = w_hs ? s_axi_wstrb : wstrb_q;
    assign ar_idx   = s_axi_araddr[ADDR_WIDTH-1:2];
    assign do_write = (wstate == W_IDLE) && (aw_have || aw_hs) && (w_have || w_hs);
    assign wr_ok    = |wr_hit;
    assign rw_regs  = rw_q;

    // Next-state register file; reads sample this so a write landing on the AR edge is visible.
    always_comb begin
        rw_next = rw_q;
        wr_hit  = '0;
        for (int k = 0; k < N_RW; k++) begin
            if (do_write && w_idx == IW'(k)) begin
                wr_hit[k] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (w_strb[b]) rw_next[k][8*b +: 8] = w_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_data = 32'h0;
        rd_err  = 1'b1;
        for (int k = 0; k < N_RW; k++) begin
            if (ar_idx == IW'(k)) begin
                rd_data = rw_next[k];
                rd_err  = 1'b0;
            end
        end
        for (int j = 0; j < N_RO; j++) begin
            if (ar_idx == IW'(N_RW + j)) begin
                rd_data = ro_regs[32*j +: 32];
                rd_err  = 1'b0;
            end
        end
    end

    always_ff @(posedge axi_clock) begin
        if (axi_reset) begin
            wstate        <= W_IDLE;
            aw_have       <= 1'b0;
            w_have        <= 1'b0;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rw_q          <= '0;
            wr_pulse      <= '0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
        end else begin
            rw_q     <= rw_next;
            wr_pulse <= wr_hit;
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) aw_idx_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
                    if (w_hs) begin
                        wdata_q <= s_axi_wdata;
                        wstrb_q <= s_axi_wstrb;
                    end
                    if (do_write) begin
                        wstate        <= W_RESP;
                        aw_have       <= 1'b0;
                        w_have        <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        s_axi_bvalid  <= 1'b1;
                        s_axi_bresp   <= wr_ok ? 2'b00 : 2'b10;
                    end else begin
                        aw_have       <= aw_have | aw_hs;
                        w_have        <= w_have | w_hs;
                        s_axi_awready <= !(aw_have | aw_hs);
                        s_axi_wready  <= !(w_have | w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        wstate        <= W_IDLE;
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge axi_clock) begin
        if (axi_reset) begin
            rstate        <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'h0;
            s_axi_rresp   <= 2'b00;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate        <= R_DATA;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rdata   <= rd_data;
                        s_axi_rresp   <= rd_err ? 2'b10 : 2'b00;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rstate        <= R_IDLE;
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
